sap1_run_control: RTL

- Top-level run/load sequencer for the SAP-1 CPU.
- Owns the T-state ring counter that feeds the instruction controller.
- Gates the datapath clock-enable for run, single-step and pause.
- Detects HLT; in load mode, writes program bytes into the 16x8 RAM through a valid/ready handshake.

---
 rtl/sap1_pkg.sv | 25 ++
 rtl/sap1_tring.sv | 25 ++
 rtl/sap1_run_control.sv | 107 ++++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// Shared constants and types for the SAP-1 run/load sequencer.
// Covers RAM geometry, T-ring length, opcodes and run-control state encodings.
package sap1_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int T_STATES = 6;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [3:0] HLT_OPCODE = OP_HLT;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALTED = 3'd4
    } run_state_e;

endpackage

// File: rtl/sap1_tring.sv
// One-hot T-state ring: bit0 = T1, rotates on en, synchronous reload to T1.
// Reload wins over advance so entering load mode always restarts the instruction.
module sap1_tring
    import sap1_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                load,
    output logic [T_STATES-1:0] ring
);

    localparam logic [T_STATES-1:0] T1 = T_STATES'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring <= T1;
        end else if (load) begin
            ring <= T1;
        end else if (en) begin
            ring <= {ring[T_STATES-2:0], ring[T_STATES-1]};
        end
    end

endmodule

// File: rtl/sap1_run_control.sv
// SAP-1 run/load sequencer: owns the T-ring, gates cpu_en for run/step/pause,
// detects HLT, and writes program bytes into RAM in load mode.
module sap1_run_control
    import sap1_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode_load,
    input  logic                run_req,
    input  logic                step_req,
    input  logic                halt_req,
    input  logic [3:0]          opcode,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   ld_data,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [T_STATES-1:0] t_state,
    output logic                cpu_en,
    output logic                cpu_clr,
    output logic                halted,
    output logic [2:0]          run_state
);

    run_state_e state, state_n;
    logic       pause_pend, pause_pend_n;
    logic       cpu_en_n, cpu_clr_n, halted_n, ld_ready_n;
    logic       running, hs, hlt_hit, t_last, ring_adv;

    // Load handshake: a byte transfers on any cycle with ld_valid && ld_ready;
    // the following cycle is the RAM write cycle, during which ld_ready is low.
    assign hs      = (state == ST_LOAD) && ld_valid && ld_ready;
    assign running = (state == ST_RUN) || (state == ST_STEP);
    assign t_last  = t_state[T_STATES-1];
    assign hlt_hit = running && t_state[3] && (opcode == HLT_OPCODE);
    // The ring freezes on the HLT T4 so the controller sees where it stopped.
    assign ring_adv = cpu_en && !hlt_hit;
    assign run_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (mode_load) begin
            state_n = ST_LOAD;
        end else begin
            unique case (state)
                ST_IDLE:   if (step_req) state_n = ST_STEP;
                           else if (run_req) state_n = ST_RUN;
                // A byte accepted on the last load cycle still gets its write cycle.
                ST_LOAD:   if (!hs) state_n = ST_IDLE;
                ST_RUN:    if (hlt_hit) state_n = ST_HALTED;
                           else if (t_last && (pause_pend || halt_req)) state_n = ST_IDLE;
                ST_STEP:   if (hlt_hit) state_n = ST_HALTED;
                           else if (t_last) state_n = ST_IDLE;
                ST_HALTED: state_n = ST_HALTED;
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_en_n     = (state_n == ST_RUN) || (state_n == ST_STEP);
        halted_n     = (state_n == ST_HALTED);
        cpu_clr_n    = (state == ST_LOAD) && (state_n == ST_IDLE);
        ld_ready_n   = (state_n == ST_LOAD) && mode_load && !hs;
        pause_pend_n = cpu_en_n && running && (pause_pend || halt_req);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_en     <= 1'b0;
            cpu_clr    <= 1'b0;
            halted     <= 1'b0;
            ld_ready   <= 1'b0;
            pause_pend <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            cpu_en     <= cpu_en_n;
            cpu_clr    <= cpu_clr_n;
            halted     <= halted_n;
            ld_ready   <= ld_ready_n;
            pause_pend <= pause_pend_n;
            ram_we     <= hs;
            if (hs) begin
                ram_addr  <= ld_addr;
                ram_wdata <= ld_data;
            end
        end
    end

    sap1_tring u_tring (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ring_adv),
        .load  (mode_load),
        .ring  (t_state)
    );

endmodule
